// File: rtl/video_timing_pkg.sv
// Shared 800x600@60 raster constants and counter widths for the video timing generator.
package video_timing_pkg;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 40;
  localparam int DEF_H_SYNC    = 128;
  localparam int DEF_H_BACK    = 88;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 1;
  localparam int DEF_V_SYNC    = 4;
  localparam int DEF_V_BACK    = 23;
  localparam int DEF_PREFETCH  = 64;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int H_W = 11;
  localparam int V_W = 10;

endpackage

// File: rtl/vt_axis.sv
// One raster axis: wrapping position counter plus registered visible/sync region flags.
// The flags are decoded from the next count so they stay aligned with count.
module vt_axis #(
  parameter int VISIBLE = 800,
  parameter int FRONT   = 40,
  parameter int SYNC    = 128,
  parameter int BACK    = 88,
  parameter int W       = 11
) (
  input  logic         CLK,
  input  logic         nRESET,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         visible,
  output logic         sync_active
);

  localparam int            TOTAL    = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0]  LAST     = W'(TOTAL - 1);
  // One extra bit so a region ending exactly at 2**W still compares correctly.
  localparam logic [W:0]    VIS_END  = (W+1)'(VISIBLE);
  localparam logic [W:0]    SYNC_BEG = (W+1)'(VISIBLE + FRONT);
  localparam logic [W:0]    SYNC_END = (W+1)'(VISIBLE + FRONT + SYNC);

  logic [W-1:0] count_next;
  logic [W:0]   next_ext;

  assign wrap     = enable && (count == LAST);
  assign next_ext = {1'b0, count_next};

  always_comb begin
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      count       <= '0;
      visible     <= (VIS_END != '0);
      sync_active <= (SYNC_BEG == '0) && (SYNC_END != '0);
    end else begin
      count       <= count_next;
      visible     <= (next_ext < VIS_END);
      sync_active <= (next_ext >= SYNC_BEG) && (next_ext < SYNC_END);
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: sync/DE/coordinates, line prefetch requests and frame events.
// Every output is a register holding the decode of the previous counter value.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int PREFETCH  = DEF_PREFETCH
) (
  input  logic           CLK,
  input  logic           nRESET,
  output logic           HSYNC,
  output logic           VSYNC,
  output logic           DE,
  output logic [H_W-1:0] X,
  output logic [V_W-1:0] Y,
  output logic           LINE_START,
  output logic           FRAME_START,
  output logic           VBLANK,
  output logic           FETCH_REQ,
  output logic [V_W-1:0] FETCH_LINE
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W) ||
      PREFETCH <= 0 || PREFETCH > H_FRONT + H_SYNC + H_BACK) begin : g_bad_params
    $error("video_timing: illegal timing parameter set");
  end

  localparam logic [H_W-1:0] FETCH_H  = H_W'(H_TOTAL - PREFETCH);
  localparam logic [V_W-1:0] V_VIS    = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_PRELST = V_W'(V_VISIBLE - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           h_wrap, h_vis, h_sync;
  logic           v_wrap_unused, v_vis, v_sync;
  logic           fetch_hit;
  logic [V_W-1:0] fetch_next;

  vt_axis #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(H_W)
  ) u_h_axis (
    .CLK(CLK), .nRESET(nRESET), .enable(1'b1),
    .count(h), .wrap(h_wrap), .visible(h_vis), .sync_active(h_sync)
  );

  vt_axis #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(V_W)
  ) u_v_axis (
    .CLK(CLK), .nRESET(nRESET), .enable(h_wrap),
    .count(v), .wrap(v_wrap_unused), .visible(v_vis), .sync_active(v_sync)
  );

  // Request only when the following line is visible; the last blank line fetches line 0.
  assign fetch_hit  = (h == FETCH_H) && ((v < V_PRELST) || (v == V_LAST));
  assign fetch_next = (v == V_LAST) ? '0 : v + 1'b1;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      HSYNC       <= !H_POL;
      VSYNC       <= !V_POL;
      DE          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      VBLANK      <= 1'b0;
      FETCH_REQ   <= 1'b0;
      FETCH_LINE  <= '0;
    end else begin
      HSYNC       <= h_sync ? H_POL : !H_POL;
      VSYNC       <= v_sync ? V_POL : !V_POL;
      DE          <= h_vis && v_vis;
      X           <= h;
      Y           <= v;
      LINE_START  <= (h == '0) && v_vis;
      FRAME_START <= (h == '0) && (v == '0);
      VBLANK      <= (h == '0) && (v == V_VIS);
      FETCH_REQ   <= fetch_hit;
      if (fetch_hit) begin
        FETCH_LINE <= fetch_next;
      end
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Directed bench: a scaled-down raster (32x16 total) for whole-frame checks, plus the
// full 800x600 geometry with inverted polarity and PREFETCH=1 for the first lines.
module tb_video_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // Scaled instance A: H 16/4/8/4 (total 32), V 10/1/2/3 (total 16), PREFETCH 6.
  logic        hs_a, vs_a, de_a, ls_a, fs_a, vb_a, fr_a;
  logic [10:0] x_a;
  logic [9:0]  y_a, fl_a;

  video_timing #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_POL(1'b1), .V_POL(1'b1), .PREFETCH(6)
  ) dut_a (
    .CLK(clk), .nRESET(rst_n), .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a), .X(x_a), .Y(y_a),
    .LINE_START(ls_a), .FRAME_START(fs_a), .VBLANK(vb_a), .FETCH_REQ(fr_a), .FETCH_LINE(fl_a)
  );

  // Instance B: default 800x600 geometry, inverted polarity, PREFETCH 1.
  logic        hs_b, vs_b, de_b, ls_b, fs_b, vb_b, fr_b;
  logic [10:0] x_b;
  logic [9:0]  y_b, fl_b;

  video_timing #(
    .H_POL(1'b0), .V_POL(1'b0), .PREFETCH(1)
  ) dut_b (
    .CLK(clk), .nRESET(rst_n), .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b), .X(x_b), .Y(y_b),
    .LINE_START(ls_b), .FRAME_START(fs_b), .VBLANK(vb_b), .FETCH_REQ(fr_b), .FETCH_LINE(fl_b)
  );

  logic [37:0] act_a, act_b;
  assign act_a = {hs_a, vs_a, de_a, ls_a, fs_a, vb_a, fr_a, x_a, y_a, fl_a};
  assign act_b = {hs_b, vs_b, de_b, ls_b, fs_b, vb_b, fr_b, x_b, y_b, fl_b};

  // Expected displayed coordinate of instance A and its held fetch line.
  int         eh, ev;
  logic [9:0] efl;

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    eh  = 0;
    ev  = 0;
    efl = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (act_a !== 38'h0) begin
      bad++;
      $display("FAIL reset_a: got %h want %h", act_a, 38'h0);
    end
    total++;
    if (act_b !== {2'b11, 36'h0}) begin
      bad++;
      $display("FAIL reset_b: got %h want %h", act_b, {2'b11, 36'h0});
    end
  endtask

  // Compares every output of A each clock against a raster decode, then checks per-frame totals.
  task automatic test_frame(input int n_frames, input string tag);
    logic        ehs, evs, ede, els, efs, evb, efr;
    logic [37:0] exp_v;
    int n_ls = 0, n_fr = 0, n_vs = 0, n_hs = 0, n_de = 0, n_vb = 0, last_fs = -1;
    for (int i = 0; i < n_frames * 512; i++) begin
      @(negedge clk);
      ehs = (eh >= 20 && eh < 28);
      evs = (ev >= 11 && ev < 13);
      ede = (eh < 16 && ev < 10);
      els = (eh == 0 && ev < 10);
      efs = (eh == 0 && ev == 0);
      evb = (eh == 0 && ev == 10);
      efr = (eh == 26 && (ev < 9 || ev == 15));
      if (efr) efl = (ev == 15) ? 10'd0 : 10'(ev + 1);
      exp_v = {ehs, evs, ede, els, efs, evb, efr, 11'(eh), 10'(ev), efl};
      total++;
      if (act_a !== exp_v) begin
        bad++;
        $display("FAIL %s h=%0d v=%0d: got %h want %h", tag, eh, ev, act_a, exp_v);
      end
      n_ls += int'(ls_a);
      n_fr += int'(fr_a);
      n_vs += int'(vs_a);
      n_hs += int'(hs_a);
      n_de += int'(de_a);
      n_vb += int'(vb_a);
      if (fs_a === 1'b1) begin
        if (last_fs >= 0) begin
          total++;
          if (i - last_fs !== 512) begin
            bad++;
            $display("FAIL %s frame_interval: got %0d want 512", tag, i - last_fs);
          end
        end
        last_fs = i;
      end
      eh++;
      if (eh == 32) begin
        eh = 0;
        ev = (ev == 15) ? 0 : ev + 1;
      end
    end
    total++;
    if (n_ls !== 10 * n_frames) begin bad++; $display("FAIL %s line_starts: got %0d want %0d", tag, n_ls, 10 * n_frames); end
    total++;
    if (n_fr !== 10 * n_frames) begin bad++; $display("FAIL %s fetch_reqs: got %0d want %0d", tag, n_fr, 10 * n_frames); end
    total++;
    if (n_vs !== 64 * n_frames) begin bad++; $display("FAIL %s vsync_clocks: got %0d want %0d", tag, n_vs, 64 * n_frames); end
    total++;
    if (n_hs !== 128 * n_frames) begin bad++; $display("FAIL %s hsync_clocks: got %0d want %0d", tag, n_hs, 128 * n_frames); end
    total++;
    if (n_de !== 160 * n_frames) begin bad++; $display("FAIL %s de_clocks: got %0d want %0d", tag, n_de, 160 * n_frames); end
    total++;
    if (n_vb !== n_frames) begin bad++; $display("FAIL %s vblanks: got %0d want %0d", tag, n_vb, n_frames); end
  endtask

  // Reset hits while both syncs are active (h=22, v=11) and is held for 3 clocks.
  task automatic test_mid_reset();
    repeat (11 * 32 + 22) @(negedge clk);
    @(negedge clk);
    total++;
    if ({hs_a, vs_a, x_a, y_a} !== {2'b11, 11'd22, 10'd11}) begin
      bad++;
      $display("FAIL pre_reset_pos: got %h want %h", {hs_a, vs_a, x_a, y_a}, {2'b11, 11'd22, 10'd11});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (act_a !== 38'h0) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", act_a, 38'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (act_a !== 38'h0) begin
        bad++;
        $display("FAIL held_reset clk%0d: got %h want %h", k, act_a, 38'h0);
      end
    end
    rst_n = 1'b1;
    eh  = 0;
    ev  = 0;
    efl = '0;
  endtask

  // Full geometry, inverted sync, fetch at h=1055: first two lines.
  task automatic test_polarity();
    int          bh, bv, n_fr = 0, n_hs_act = 0;
    logic [9:0]  bfl;
    logic        efr;
    logic [37:0] exp_v;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (act_b !== {2'b11, 36'h0}) begin
      bad++;
      $display("FAIL pol_reset_b: got %h want %h", act_b, {2'b11, 36'h0});
    end
    rst_n = 1'b1;
    bh  = 0;
    bv  = 0;
    bfl = '0;
    for (int i = 0; i < 2 * 1056; i++) begin
      @(negedge clk);
      efr = (bh == 1055);
      if (efr) bfl = 10'(bv + 1);
      exp_v = {!(bh >= 840 && bh < 968), 1'b1, bh < 800, bh == 0, bh == 0 && bv == 0,
               1'b0, efr, 11'(bh), 10'(bv), bfl};
      total++;
      if (act_b !== exp_v) begin
        bad++;
        $display("FAIL polarity h=%0d v=%0d: got %h want %h", bh, bv, act_b, exp_v);
      end
      n_fr += int'(fr_b);
      n_hs_act += int'(!hs_b);
      bh++;
      if (bh == 1056) begin
        bh = 0;
        bv++;
      end
    end
    total++;
    if (n_fr !== 2) begin bad++; $display("FAIL pol_fetch_count: got %0d want 2", n_fr); end
    total++;
    if (n_hs_act !== 256) begin bad++; $display("FAIL pol_hsync_clocks: got %0d want 256", n_hs_act); end
  endtask

  initial begin
    test_reset();
    release_reset();
    test_frame(2, "frame_run");
    test_mid_reset();
    test_frame(2, "after_reset");
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
